// File: rtl/cache_refill_writer_if.sv
// Bundle of request, AXI read, RAM write and completion signals
// around the cache refill writer.
interface cache_refill_writer_if #(
    parameter int SET_WIDTH    = 6,
    parameter int OFFSET_WIDTH = 3,
    parameter int DATA_WIDTH   = 32
);
    logic                              req_valid;
    logic                              req_ready;
    logic [31:0]                       req_paddr;
    logic [SET_WIDTH-1:0]              req_set;
    logic                              arvalid;
    logic                              arready;
    logic [31:0]                       araddr;
    logic [7:0]                        arlen;
    logic [2:0]                        arsize;
    logic [1:0]                        arburst;
    logic                              rvalid;
    logic                              rready;
    logic [DATA_WIDTH-1:0]             rdata;
    logic [1:0]                        rresp;
    logic                              rlast;
    logic                              ram_wr_en;
    logic                              ram_wr_mask;
    logic [SET_WIDTH+OFFSET_WIDTH-1:0] ram_wr_addr;
    logic [DATA_WIDTH-1:0]             ram_wr_data;
    logic                              ram_busy;
    logic                              fwd_valid;
    logic [DATA_WIDTH-1:0]             fwd_data;
    logic                              done_valid;
    logic                              done_err;

    modport master (
        input  req_valid, req_paddr, req_set,
        input  arready, rvalid, rdata, rresp, rlast,
        output req_ready, arvalid, araddr, arlen, arsize, arburst,
        output rready, ram_wr_en, ram_wr_mask, ram_wr_addr,
        output ram_wr_data, ram_busy, fwd_valid, fwd_data,
        output done_valid, done_err
    );

    modport slave (
        output req_valid, req_paddr, req_set,
        output arready, rvalid, rdata, rresp, rlast,
        input  req_ready, arvalid, araddr, arlen, arsize, arburst,
        input  rready, ram_wr_en, ram_wr_mask, ram_wr_addr,
        input  ram_wr_data, ram_busy, fwd_valid, fwd_data,
        input  done_valid, done_err
    );
endinterface

// File: rtl/cache_refill_writer.sv
// Cache line refill: one AXI INCR burst per miss, each beat written
// into the data RAM at {set, beat}, critical word forwarded.
module cache_refill_writer #(
    parameter int SET_WIDTH    = 6,
    parameter int OFFSET_WIDTH = 3,
    parameter int DATA_WIDTH   = 32
) (
    input logic                   aclk,
    input logic                   aresetn,
    cache_refill_writer_if.master bus
);
    localparam int LINE_WORDS = 1 << OFFSET_WIDTH;
    localparam logic [OFFSET_WIDTH-1:0] LAST_BEAT =
        OFFSET_WIDTH'(LINE_WORDS - 1);

    typedef enum logic [2:0] {IDLE, AR, R, FLUSH, DONE} state_t;

    state_t                            state;
    logic [SET_WIDTH-1:0]              set_q;
    logic [OFFSET_WIDTH-1:0]           word_q;
    logic [OFFSET_WIDTH-1:0]           beat_cnt;
    logic                              err;
    logic                              req_ready_q;
    logic                              arvalid_q;
    logic [31:0]                       araddr_q;
    logic                              rready_q;
    logic                              wr_en_q;
    logic [SET_WIDTH+OFFSET_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0]             wr_data_q;
    logic                              fwd_valid_q;
    logic [DATA_WIDTH-1:0]             fwd_data_q;
    logic                              done_valid_q;
    logic                              done_err_q;
    logic                              beat;
    logic                              unused_paddr;

    assign beat = bus.rvalid && rready_q;
    // Byte offset within a word never matters for a line fill.
    assign unused_paddr = ^bus.req_paddr[1:0];

    // Refill FSM with all outputs registered.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= IDLE;
            set_q        <= '0;
            word_q       <= '0;
            beat_cnt     <= '0;
            err          <= 1'b0;
            req_ready_q  <= 1'b1;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            rready_q     <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            fwd_valid_q  <= 1'b0;
            fwd_data_q   <= '0;
            done_valid_q <= 1'b0;
            done_err_q   <= 1'b0;
        end else begin
            wr_en_q      <= 1'b0;
            fwd_valid_q  <= 1'b0;
            done_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        state       <= AR;
                        req_ready_q <= 1'b0;
                        arvalid_q   <= 1'b1;
                        set_q       <= bus.req_set;
                        word_q      <= bus.req_paddr[OFFSET_WIDTH+1:2];
                        araddr_q    <= {bus.req_paddr[31:OFFSET_WIDTH+2],
                                        {(OFFSET_WIDTH+2){1'b0}}};
                        beat_cnt    <= '0;
                        err         <= 1'b0;
                    end
                end
                AR: begin
                    if (bus.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= R;
                    end
                end
                R: begin
                    if (beat) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= {set_q, beat_cnt};
                        wr_data_q <= bus.rdata;
                        beat_cnt  <= beat_cnt + 1'b1;
                        if (beat_cnt == word_q) begin
                            fwd_valid_q <= 1'b1;
                            fwd_data_q  <= bus.rdata;
                        end
                        if (bus.rresp != 2'b00) begin
                            err <= 1'b1;
                        end
                        // Beat count decides the end of line; rlast only
                        // flags a protocol error when it disagrees.
                        if (beat_cnt == LAST_BEAT) begin
                            rready_q <= 1'b0;
                            state    <= FLUSH;
                            if (!bus.rlast) begin
                                err <= 1'b1;
                            end
                        end else if (bus.rlast) begin
                            rready_q <= 1'b0;
                            state    <= FLUSH;
                            err      <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    done_valid_q <= 1'b1;
                    done_err_q   <= err;
                    state        <= DONE;
                end
                DONE: begin
                    req_ready_q <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    req_ready_q <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.arvalid     = arvalid_q;
    assign bus.araddr      = araddr_q;
    assign bus.arlen       = 8'(LINE_WORDS - 1);
    assign bus.arsize      = 3'b010;
    assign bus.arburst     = 2'b01;
    assign bus.rready      = rready_q;
    assign bus.ram_wr_en   = wr_en_q;
    assign bus.ram_wr_mask = wr_en_q;
    assign bus.ram_wr_addr = wr_addr_q;
    assign bus.ram_wr_data = wr_data_q;
    assign bus.ram_busy    = (state != IDLE) || wr_en_q;
    assign bus.fwd_valid   = fwd_valid_q;
    assign bus.fwd_data    = fwd_data_q;
    assign bus.done_valid  = done_valid_q;
    assign bus.done_err    = done_err_q;
endmodule

// File: tb/tb_cache_refill_writer.sv
// Directed bench for cache_refill_writer with a scoreboard of
// expected RAM writes and forwarded words.
module tb_cache_refill_writer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [8:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wr_q[$];
    logic [31:0] fwd_q[$];
    wr_t         ewr;
    logic [31:0] efwd;

    always #5 clk = ~clk;

    cache_refill_writer_if #(
        .SET_WIDTH(6), .OFFSET_WIDTH(3), .DATA_WIDTH(32)
    ) bus ();

    cache_refill_writer #(
        .SET_WIDTH(6), .OFFSET_WIDTH(3), .DATA_WIDTH(32)
    ) dut (
        .aclk(clk),
        .aresetn(rst_n),
        .bus(bus.master)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every RAM write and forward must match the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ram_wr_en === 1'b1) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_wr", 64'(bus.ram_wr_en), 64'(0));
                end else begin
                    ewr = wr_q.pop_front();
                    chk("wr_addr", 64'(bus.ram_wr_addr), 64'(ewr.addr));
                    chk("wr_data", 64'(bus.ram_wr_data), 64'(ewr.data));
                    chk("wr_mask", 64'(bus.ram_wr_mask), 64'(1));
                    chk("busy_wr", 64'(bus.ram_busy), 64'(1));
                end
            end
            if (bus.fwd_valid === 1'b1) begin
                if (fwd_q.size() == 0) begin
                    chk("unexpected_fwd", 64'(bus.fwd_valid), 64'(0));
                end else begin
                    efwd = fwd_q.pop_front();
                    chk("fwd_data", 64'(bus.fwd_data), 64'(efwd));
                end
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'(1));
        chk({tag, "_arvalid"}, 64'(bus.arvalid), 64'(0));
        chk({tag, "_rready"}, 64'(bus.rready), 64'(0));
        chk({tag, "_wr_en"}, 64'(bus.ram_wr_en), 64'(0));
        chk({tag, "_busy"}, 64'(bus.ram_busy), 64'(0));
        chk({tag, "_fwd"}, 64'(bus.fwd_valid), 64'(0));
        chk({tag, "_done"}, 64'(bus.done_valid), 64'(0));
        chk({tag, "_araddr"}, 64'(bus.araddr), 64'(0));
    endtask

    // last_beat: beat carrying rlast (8 = none); abort_after: reset
    // just after that beat's edge (-1 = never).
    task automatic refill(input logic [31:0] paddr, input logic [5:0] set,
                          input int arwait, input bit gap,
                          input int err_beat, input int last_beat,
                          input int abort_after, input logic [31:0] base);
        int nbeats;
        logic [2:0] word;
        logic exp_err;
        logic [31:0] exp_araddr;
        wr_t w;
        nbeats = (last_beat < 7) ? last_beat + 1 : 8;
        word = paddr[4:2];
        exp_araddr = paddr & 32'hFFFF_FFE0;
        exp_err = (err_beat >= 0 && err_beat < nbeats) || (last_beat != 7);

        @(negedge clk);
        chk("req_ready_idle", 64'(bus.req_ready), 64'(1));
        bus.req_valid = 1'b1;
        bus.req_paddr = paddr;
        bus.req_set = set;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_paddr = 32'hDEAD_BEEF;
        chk("arvalid", 64'(bus.arvalid), 64'(1));
        chk("araddr", 64'(bus.araddr), 64'(exp_araddr));
        chk("arlen", 64'(bus.arlen), 64'(7));
        chk("arsize", 64'(bus.arsize), 64'(2));
        chk("arburst", 64'(bus.arburst), 64'(1));
        chk("req_ready_busy", 64'(bus.req_ready), 64'(0));
        for (int k = 0; k < arwait; k++) begin
            @(negedge clk);
            chk("arvalid_hold", 64'(bus.arvalid), 64'(1));
            chk("araddr_hold", 64'(bus.araddr), 64'(exp_araddr));
        end
        bus.arready = 1'b1;
        @(negedge clk);
        bus.arready = 1'b0;
        chk("rready", 64'(bus.rready), 64'(1));
        chk("arvalid_drop", 64'(bus.arvalid), 64'(0));

        for (int i = 0; i < nbeats; i++) begin
            if (gap && i > 0) begin
                bus.rvalid = 1'b0;
                @(negedge clk);
            end
            bus.rvalid = 1'b1;
            bus.rdata = base + 32'(i);
            bus.rresp = (i == err_beat) ? 2'b10 : 2'b00;
            bus.rlast = (i == last_beat);
            w.addr = {set, 3'(i)};
            w.data = base + 32'(i);
            wr_q.push_back(w);
            if (3'(i) == word) fwd_q.push_back(base + 32'(i));
            if (i == abort_after) begin
                @(posedge clk);
                #2;
                rst_n = 1'b0;
                bus.rvalid = 1'b0;
                bus.rlast = 1'b0;
                bus.rresp = 2'b00;
                #1;
                chk_reset_outputs("abort");
                wr_q.delete();
                fwd_q.delete();
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                chk("req_ready_release", 64'(bus.req_ready), 64'(1));
                return;
            end
            @(negedge clk);
        end
        bus.rvalid = 1'b0;
        bus.rlast = 1'b0;
        bus.rresp = 2'b00;
        chk("flush_no_done", 64'(bus.done_valid), 64'(0));
        chk("flush_busy", 64'(bus.ram_busy), 64'(1));
        chk("flush_rready", 64'(bus.rready), 64'(0));
        @(negedge clk);
        chk("done_valid", 64'(bus.done_valid), 64'(1));
        chk("done_err", 64'(bus.done_err), 64'(exp_err));
        @(negedge clk);
        chk("done_pulse", 64'(bus.done_valid), 64'(0));
        chk("req_ready_back", 64'(bus.req_ready), 64'(1));
        chk("busy_idle", 64'(bus.ram_busy), 64'(0));
        chk("wr_q_drained", 64'(wr_q.size()), 64'(0));
        chk("fwd_q_drained", 64'(fwd_q.size()), 64'(0));
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_paddr = '0;
        bus.req_set = '0;
        bus.arready = 1'b0;
        bus.rvalid = 1'b0;
        bus.rdata = '0;
        bus.rresp = 2'b00;
        bus.rlast = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        refill(32'h0000_1234, 6'd5, 0, 1'b0, -1, 7, -1, 32'hA0);
        refill(32'h8000_0ABC, 6'd17, 3, 1'b1, -1, 7, -1, 32'hB0);
        refill(32'h0000_0048, 6'd2, 0, 1'b0, 3, 7, -1, 32'hC0);
        refill(32'h0000_101C, 6'd9, 0, 1'b0, -1, 4, -1, 32'hD0);
        refill(32'h0000_2008, 6'd33, 0, 1'b0, -1, 8, -1, 32'hE0);
        refill(32'h0000_3010, 6'd63, 0, 1'b0, -1, 7, 2, 32'hF0);
        refill(32'h0000_4444, 6'd12, 1, 1'b0, -1, 7, -1, 32'h100);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
